// File: rtl/orb_desc_pkg.sv
// ============================================================================
// Module : orb_desc_pkg
// Brief  : Shared types for the ORB descriptor dispatch pool (engine state, order token).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package orb_desc_pkg;

    localparam int MAX_ENG = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_RUN  = 2'd1,
        ENG_HOLD = 2'd2
    } eng_state_t;

    // Index is sized for the largest pool; smaller pools leave upper bits zero.
    typedef struct packed {
        logic             drop;
        logic [IDX_W-1:0] idx;
    } token_t;

endpackage

`default_nettype wire

// File: rtl/desc_order_fifo.sv
// ============================================================================
// Module : desc_order_fifo
// Brief  : DEPTH-entry synchronous token FIFO; a pop frees its slot for a same-cycle push.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module desc_order_fifo
    import orb_desc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  token_t                   din,
    input  logic                     pop,
    output token_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

    token_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [PW:0]     r_cnt;
    logic            w_push;
    logic            w_pop;

    assign full   = (r_cnt == C_DEPTH);
    assign empty  = (r_cnt == '0);
    assign count  = r_cnt;
    assign dout   = r_mem[r_rp];
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/descriptor_dispatch_pool.sv
// ============================================================================
// Module : descriptor_dispatch_pool
// Brief  : Round-robin dispatcher / in-order retirer for N_ENG descriptor engines.
//          Optional drop_cnt output enabled by macro DESC_DROP_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module descriptor_dispatch_pool
    import orb_desc_pkg::*;
#(
    parameter int N_ENG  = 4,
    parameter int DESC_W = 256,
    parameter int QDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      corner_valid,
    output logic [N_ENG-1:0]          eng_start,
    input  logic [N_ENG-1:0]          eng_done,
    input  logic [N_ENG*DESC_W-1:0]   eng_desc,
    output logic [DESC_W-1:0]         out_desc,
    output logic                      out_dropped,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      is_full,
`ifdef DESC_DROP_CNT_EN
    output logic [15:0]               drop_cnt,
`endif
    output logic                      overflow
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] C_QDEPTH = CW'(QDEPTH);

    logic [IDX_W-1:0]          r_rr;
    logic                      r_overflow;
    logic [N_ENG-1:0]          w_idle;
    logic [N_ENG-1:0]          w_is_hold;
    logic [N_ENG*DESC_W-1:0]   w_hold_bus;
    logic                      w_found;
    logic [IDX_W-1:0]          w_sel;
    int                        w_best;
    int                        w_dist;
    token_t                    w_head;
    token_t                    w_tok;
    logic                      w_full;
    logic                      w_empty;
    logic [CW-1:0]             w_count;
    logic                      w_head_hold;
    logic [DESC_W-1:0]         w_head_desc;
    logic                      w_req;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_lost;
    logic                      w_dispatch;

    // Nearest IDLE engine at or after rr_ptr, measured as circular distance.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_best  = N_ENG;
        w_dist  = 0;
        for (int i = 0; i < N_ENG; i++) begin
            w_dist = (i >= int'(r_rr)) ? i - int'(r_rr) : i + N_ENG - int'(r_rr);
            if (w_idle[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_sel   = IDX_W'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_head_hold = 1'b0;
        w_head_desc = '0;
        for (int i = 0; i < N_ENG; i++) begin
            if (int'(w_head.idx) == i) begin
                w_head_hold = w_is_hold[i];
                w_head_desc = w_hold_bus[i*DESC_W +: DESC_W];
            end
        end
    end

    assign out_valid   = ~w_empty & (w_head.drop | w_head_hold);
    assign out_dropped = ~w_empty & w_head.drop;
    assign out_desc    = (~w_empty & ~w_head.drop & w_head_hold) ? w_head_desc : '0;
    assign is_full     = ~(|w_idle) | (w_count == C_QDEPTH);
    assign overflow    = r_overflow;

    assign w_req      = ena & corner_valid;
    assign w_pop      = out_valid & out_ready;
    assign w_push     = w_req & (~w_full | w_pop);
    assign w_lost     = w_req & w_full & ~w_pop;
    assign w_dispatch = w_push & w_found;
    assign w_tok.drop = ~w_found;
    assign w_tok.idx  = w_found ? w_sel : '0;

    desc_order_fifo #(
        .DEPTH (QDEPTH)
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_tok),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    for (genvar gi = 0; gi < N_ENG; gi++) begin : g_eng
        localparam logic [IDX_W-1:0] C_IDX = IDX_W'(gi);

        eng_state_t          r_state;
        logic [DESC_W-1:0]   r_hold;
        logic                r_start;
        logic                w_sel_me;
        logic                w_ret_me;

        assign w_sel_me = w_dispatch & (w_sel == C_IDX);
        assign w_ret_me = w_pop & ~w_head.drop & (w_head.idx == C_IDX);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ENG_IDLE;
                r_start <= 1'b0;
            end else begin
                r_start <= w_sel_me;
                case (r_state)
                    ENG_IDLE: if (w_sel_me)     r_state <= ENG_RUN;
                    ENG_RUN:  if (eng_done[gi]) r_state <= ENG_HOLD;
                    ENG_HOLD: if (w_ret_me)     r_state <= ENG_IDLE;
                    default:                    r_state <= ENG_IDLE;
                endcase
            end
        end

        // Held data is only visible in HOLD, so it needs no reset.
        always_ff @(posedge clk) begin
            if ((r_state == ENG_RUN) && eng_done[gi])
                r_hold <= eng_desc[gi*DESC_W +: DESC_W];
        end

        assign eng_start[gi]                     = r_start;
        assign w_idle[gi]                        = (r_state == ENG_IDLE);
        assign w_is_hold[gi]                     = (r_state == ENG_HOLD);
        assign w_hold_bus[gi*DESC_W +: DESC_W]   = r_hold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_dispatch)
                r_rr <= (int'(w_sel) == N_ENG - 1) ? '0 : w_sel + 1'b1;
            if (w_lost)
                r_overflow <= 1'b1;
        end
    end

`ifdef DESC_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (((w_push & ~w_found) | w_lost) && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire
